// File: rtl/mips_div_pkg.sv
// Shared constants, state codes and result payload for the mips_div divider.
package mips_div_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RES_W  = 64;
   localparam int unsigned CNT_W  = 5;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(31);
   localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(0);

   // start_i levels
   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   // ready_o levels
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   // Divider FSM state codes
   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   // {remainder, quotient} as forwarded toward HI/LO
   typedef struct packed {
      logic [DATA_W-1:0] rem;
      logic [DATA_W-1:0] quo;
   } div_result_t;

endpackage : mips_div_pkg

// File: rtl/div_negate.sv
// Conditional two's-complement negation of a 32-bit word.
module div_negate
   import mips_div_pkg::*;
(
   input  logic              en,
   input  logic [DATA_W-1:0] val,
   output logic [DATA_W-1:0] val_c
);

   // Negate when enabled, pass through otherwise
   assign val_c = en ? DATA_W'(~val + 1'b1) : val;

endmodule : div_negate

// File: rtl/mips_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, {remainder, quotient} result.
// Optional feature: define MIPS_DIV_EARLY_OUT_EN to skip the iteration when |op1| < |op2|.
module mips_div
   import mips_div_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              signed_div_i,
   input  logic [DATA_W-1:0] opdata1_i,
   input  logic [DATA_W-1:0] opdata2_i,
   input  logic              start_i,
   input  logic              annul_i,
   output logic [RES_W-1:0]  result_o,
   output logic              ready_o
);

   div_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] dvd;      // dividend shifting out, quotient shifting in
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] dvs;
   logic              neg_q;
   logic              neg_r;
   div_result_t       res;

   logic [DATA_W-1:0] op1_abs, op2_abs;
   logic [DATA_W:0]   trial, diff;
   logic              qbit;
   logic [DATA_W-1:0] rem_step, quo_step;
   logic [DATA_W-1:0] q_fix, r_fix;
   logic              early_c;
   logic              go_c;

   // Operand magnitudes for signed division
   div_negate u_neg_op1 (.en(signed_div_i & opdata1_i[DATA_W-1]), .val(opdata1_i), .val_c(op1_abs));
   div_negate u_neg_op2 (.en(signed_div_i & opdata2_i[DATA_W-1]), .val(opdata2_i), .val_c(op2_abs));

   // One restoring step: shift in next dividend bit, trial-subtract divisor
   always_comb begin
      trial    = {rem, dvd[DATA_W-1]};
      diff     = trial - {1'b0, dvs};
      qbit     = ~diff[DATA_W];
      rem_step = qbit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
      quo_step = {dvd[DATA_W-2:0], qbit};
   end

   // Sign fix-up of the final step's quotient and remainder
   div_negate u_neg_quo (.en(neg_q), .val(quo_step), .val_c(q_fix));
   div_negate u_neg_rem (.en(neg_r), .val(rem_step), .val_c(r_fix));

`ifdef MIPS_DIV_EARLY_OUT_EN
   // Dividend smaller than divisor: quotient 0, remainder is the dividend
   assign early_c = (opdata2_i != ZERO_WORD) && (op1_abs < op2_abs);
`else
   assign early_c = 1'b0;
`endif

   assign go_c = (start_i == DIV_START) && !annul_i;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DIV_FREE;
      else     state <= state_nxt;
   end

   // Next-state logic; annul aborts any non-idle state
   always_comb begin
      state_nxt = state;
      unique case (state)
         DIV_FREE: begin
            if (go_c) begin
               if (opdata2_i == ZERO_WORD) state_nxt = DIV_BY_ZERO;
               else if (early_c)           state_nxt = DIV_END;
               else                        state_nxt = DIV_ON;
            end
         end
         DIV_BY_ZERO: state_nxt = annul_i ? DIV_FREE : DIV_END;
         DIV_ON: begin
            if (annul_i)              state_nxt = DIV_FREE;
            else if (cnt == CNT_LAST) state_nxt = DIV_END;
         end
         DIV_END: begin
            if (annul_i || start_i == DIV_STOP) state_nxt = DIV_FREE;
         end
      endcase
   end

   // Datapath: operand capture, iteration and final result latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         dvd   <= '0;
         rem   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         res   <= '0;
      end else begin
         unique case (state)
            DIV_FREE: begin
               if (go_c && opdata2_i != ZERO_WORD) begin
                  dvd   <= op1_abs;
                  dvs   <= op2_abs;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                  neg_r <= signed_div_i & opdata1_i[DATA_W-1];
                  res   <= early_c ? '{rem: opdata1_i, quo: ZERO_WORD} : '0;
               end
            end
            DIV_BY_ZERO: res <= '0;
            DIV_ON: begin
               if (!annul_i) begin
                  rem <= rem_step;
                  dvd <= quo_step;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) res <= '{rem: r_fix, quo: q_fix};
               end
            end
            DIV_END: ;
         endcase
      end
   end

   // Registered outputs: valid only while the result is presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
      end else if (!annul_i && state == DIV_BY_ZERO) begin
         result_o <= '0;
         ready_o  <= start_i;
      end else if (!annul_i && state == DIV_END && start_i == DIV_START) begin
         result_o <= res;
         ready_o  <= DIV_RESULT_READY;
      end else begin
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
      end
   end

endmodule : mips_div

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div against an arithmetic reference model.
module tb_mips_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int          total = 0;
   int          bad   = 0;
   logic        exp_ready  = 1'b0;
   logic [63:0] exp_result = 64'h0;
   logic        pin_en     = 1'b0;
   logic [63:0] pin_exp    = 64'h0;
   string       pin_name   = "";
   int          cyc = 0;

   mips_div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   // Reference: MIPS DIV/DIVU semantics from plain arithmetic
   function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int sa, sb, q, r;
      if (b == 32'h0) return 64'h0;
      if (!sgn) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
   endfunction

   function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
      return (sgn && x[31]) ? 32'(-x) : x;
   endfunction

   // Edges from start sample to first ready cycle
   function automatic int latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'h0) return 2;
`ifdef MIPS_DIV_EARLY_OUT_EN
      if (mag(sgn, a) < mag(sgn, b)) return 2;
`endif
      return 34;
   endfunction

   // Single compare process: outputs every cycle, plus pinned literals
   always @(negedge clk) begin
      cyc <= cyc + 1;
      total = total + 1;
      if (ready_o !== exp_ready || result_o !== exp_result) begin
         bad = bad + 1;
         $display("FAIL outputs cyc=%0d: ready=%b result=%h, expected ready=%b result=%h",
                  cyc, ready_o, result_o, exp_ready, exp_result);
      end
      if (pin_en) begin
         total = total + 1;
         if (result_o !== pin_exp) begin
            bad = bad + 1;
            $display("FAIL %s: result=%h, expected %h", pin_name, result_o, pin_exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one division with start held; optionally pin the result to a literal
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit rel,
                          input bit pin, input logic [63:0] pval, input string pname);
      int lat;
      logic [63:0] r;
      lat = latency(sgn, a, b);
      r   = model(sgn, a, b);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      for (int e = 1; e <= lat; e++) begin
         tick();
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         if (e == lat) begin
            exp_ready  = 1'b1;
            exp_result = r;
         end
      end
      if (pin) begin
         pin_name = pname;
         pin_exp  = pval;
         pin_en   = 1'b1;
         @(negedge clk);
         #1;
         pin_en = 1'b0;
      end
      for (int h = 0; h < hold; h++) tick();
      if (rel) begin
         start_i = 1'b0;
         tick();
         exp_ready  = 1'b0;
         exp_result = 64'h0;
      end
   endtask

   // Start a division and annul it before edge k+1
   task automatic annul_at(input int k, input bit keep_start);
      signed_div_i = 1'b0;
      opdata1_i    = 32'h7FFF_0000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      for (int e = 0; e < k; e++) tick();
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      if (!keep_start) begin
         start_i = 1'b0;
         tick();
      end
   endtask

   initial begin
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = 32'h0;
      opdata2_i    = 32'h0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_div(1'b0, 32'd7, 32'd2, 3, 1'b1, 1'b1, 64'h00000001_00000003, "udiv_7_2");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "sdiv_m7_2");
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b1, 1'b1, 64'h00000001_FFFFFFFD, "sdiv_7_m2");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1, 1'b1, 64'h00000000_80000000, "sdiv_ovf");
      run_div(1'b1, 32'h1234_5678, 32'h0, 2, 1'b1, 1'b1, 64'h0, "sdiv_zero");
      run_div(1'b0, 32'hFFFF_FFFF, 32'h0, 0, 1'b1, 1'b1, 64'h0, "udiv_zero");
      run_div(1'b0, 32'd3, 32'd5, 1, 1'b1, 1'b1, 64'h00000003_00000000, "udiv_3_5");
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1, 1'b1, 64'h00000000_FFFFFFFF, "udiv_max_1");

      annul_at(11, 1'b1);
      run_div(1'b0, 32'd100, 32'd7, 1, 1'b1, 1'b1, 64'h00000002_0000000E, "udiv_after_annul");
      annul_at(32, 1'b0);
      annul_at(33, 1'b0);

      // Asynchronous reset mid-iteration
      signed_div_i = 1'b0;
      opdata1_i    = 32'hDEAD_BEEF;
      opdata2_i    = 32'd9;
      start_i      = 1'b1;
      for (int e = 0; e < 15; e++) tick();
      #3;
      rst     = 1'b1;
      start_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 1'b1, 1'b1, 64'hFFFFFFFE_FFFFFFF2, "sdiv_m100_7");

      // Asynchronous reset while the result is presented
      run_div(1'b0, 32'd1000, 32'd10, 1, 1'b0, 1'b0, 64'h0, "");
      #3;
      rst        = 1'b1;
      start_i    = 1'b0;
      exp_ready  = 1'b0;
      exp_result = 64'h0;
      tick();
      rst = 1'b0;
      tick();

      // Randomized operands across the interesting corners
      for (int n = 0; n < 40; n++) begin
         logic        s;
         logic [31:0] a, b;
         int          kind;
         s    = 1'($urandom_range(0, 1));
         a    = $urandom;
         b    = $urandom;
         kind = $urandom_range(0, 5);
         case (kind)
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: ;
            4: a = 32'($urandom_range(0, 200));
            default: b = b >> $urandom_range(0, 31);
         endcase
         run_div(s, a, b, $urandom_range(0, 3), 1'b1, 1'b0, 64'h0, "");
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mips_div
